// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared constants and FSM state type for the fetch queue
package ifetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic {RUN, DRAIN} state_t;
endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// sync_fifo: count-based synchronous FIFO with clear; DEPTH must be a power of 2
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst || clear) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: credit-limited in-order fetch queue between PC and decode, with flush drain
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = ifetch_queue_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_ready,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_misalign,
  input  logic            id_ready
);
  import ifetch_queue_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * XLEN + 1;
  state_t state, state_nx;
  logic [CW-1:0] inflight, occupancy, discard, left;
  logic accept, resp, drop, fl, pop, pc_empty, pc_full, d_empty, d_full;
  logic [XLEN-1:0] head_pc;
  logic [EW-1:0] d_head;
  assign fl = state == RUN && flush;
  assign resp = state == RUN && mem_rvalid && inflight != '0;
  assign drop = state == DRAIN && mem_rvalid && discard != '0;
  assign left = inflight - CW'(resp);
  assign accept = pc_valid && pc_ready;
  assign pop = if_valid && id_ready;
  assign mem_req = accept;
  assign mem_addr = {pc_addr[XLEN-1:2], 2'b00};
  always_ff @(posedge clk)
    state <= rst ? RUN : state_nx;
  always_comb
    state_nx = state == RUN ? ((fl && left != '0) ? DRAIN : RUN)
                            : ((drop && discard == CW'(1)) ? RUN : DRAIN);
  always_comb begin
    pc_ready = !rst && state == RUN && !flush
               && ({1'b0, inflight} + {1'b0, occupancy} < (CW+1)'(DEPTH));
    if_valid = !rst && state == RUN && !flush && !d_empty;
  end
  // A response landing in the flush cycle is already accounted for, so it is not drained.
  always_ff @(posedge clk)
    if (rst) begin
      inflight <= '0;
      occupancy <= '0;
      discard <= '0;
    end else if (fl) begin
      inflight <= '0;
      occupancy <= '0;
      discard <= left;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(resp);
      occupancy <= occupancy + CW'(resp) - CW'(pop);
      if (drop) discard <= discard - CW'(1);
    end
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
    .clk(clk), .rst(rst), .clear(fl), .push(accept), .din(pc_addr), .pop(resp),
    .dout(head_pc), .empty(pc_empty), .full(pc_full)
  );
  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_data_fifo (
    .clk(clk), .rst(rst), .clear(fl), .push(resp),
    .din({head_pc[1:0] != 2'b00, head_pc, mem_rdata}), .pop(pop),
    .dout(d_head), .empty(d_empty), .full(d_full)
  );
  assign if_misalign = d_head[EW-1];
  assign if_pc = d_head[2*XLEN-1:XLEN];
  assign if_instr = if_misalign ? XLEN'(NOP_INSTR) : d_head[XLEN-1:0];
  always_ff @(posedge clk)
    if (!rst) begin
      assert (!(mem_rvalid && inflight == '0 && discard == '0));
      assert (!(accept && pc_full) && !(resp && (pc_empty || d_full)));
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed tests with a memory responder and a scoreboard monitor
module tb_ifetch_queue;
  logic clk, rst, pc_valid, flush, mem_rvalid, id_ready;
  logic [31:0] pc_addr, mem_rdata;
  logic pc_ready, mem_req, if_valid, if_misalign;
  logic [31:0] mem_addr, if_instr, if_pc;

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } exp_t;
  typedef struct { int due; logic [31:0] addr; } pend_t;
  exp_t exp_q[$];
  exp_t e;
  pend_t pend[$];
  int pop_cyc[$];
  int vec, miss, pops, acc, cyc, lat;
  logic took;

  ifetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_ready(pc_ready),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_misalign(if_misalign), .id_ready(id_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // memory: returns ~addr, lat cycles after the request; forgets everything on reset
  always @(negedge clk) begin
    if (rst) pend.delete();
    else if (mem_req) pend.push_back('{cyc + lat, mem_addr});
  end
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1;
      mem_rdata = ~pend[0].addr;
      void'(pend.pop_front());
    end else mem_rvalid = 0;
  end

  // scoreboard monitor: compare consumed entries, then record newly accepted fetches
  always @(negedge clk) begin
    if (!rst && if_valid && id_ready) begin
      pops++;
      pop_cyc.push_back(cyc);
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL sb_extra: got pc %h instr %h, expected no output", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        if ({if_misalign, if_pc, if_instr} !== {e.mis, e.pc, e.instr}) begin
          miss++;
          $display("FAIL sb_entry: got pc %h instr %h mis %b, expected pc %h instr %h mis %b",
                   if_pc, if_instr, if_misalign, e.pc, e.instr, e.mis);
        end
      end
    end
    if (rst || flush) exp_q.delete();
    else if (pc_valid && pc_ready) begin
      acc++;
      exp_q.push_back('{pc_addr, pc_addr[1:0] != 0 ? 32'h00000013 : ~{pc_addr[31:2], 2'b00},
                        pc_addr[1:0] != 0});
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    vec++;
    if (a !== x) begin
      miss++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; pc_valid = 1; pc_addr = 0; flush = 0; id_ready = 0;
    mem_rvalid = 0; mem_rdata = 0; lat = 1; cyc = 0;
    vec = 0; miss = 0; pops = 0; acc = 0;
    // 1: reset, then four back-to-back fetches drain one per cycle
    @(negedge clk);
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    tick(1);
    rst = 0; id_ready = 1; pop_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      pc_addr = 32'(i * 4);
      @(negedge clk);
      chk("t1_accept", pc_ready, 1);
      tick(1);
    end
    pc_valid = 0;
    tick(6);
    chk("t1_pops", pops, 4);
    for (int i = 1; i < 4; i++) chk("t1_rate", pop_cyc[i] - pop_cyc[i-1], 1);
    // 2: credit limit with decode stalled
    id_ready = 0; pc_valid = 1; pc_addr = 32'h100; acc = 0; pops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      took = pc_valid && pc_ready;
      tick(1);
      if (took) pc_addr += 4;
    end
    chk("t2_accepts", acc, 4);
    @(negedge clk);
    chk("t2_full", pc_ready, 0);
    tick(1);
    id_ready = 1;
    @(negedge clk);
    chk("t2_pop_valid", if_valid, 1);
    chk("t2_pop_no_credit", pc_ready, 0);
    tick(1);
    id_ready = 0;
    @(negedge clk);
    chk("t2_credit", pc_ready, 1);
    tick(1);
    pc_valid = 0;
    @(negedge clk);
    chk("t2_refull", pc_ready, 0);
    chk("t2_accepts5", acc, 5);
    id_ready = 1;
    tick(8);
    chk("t2_pops", pops, 5);
    // 3: flush with two fetches in flight drains both responses
    lat = 3; pops = 0; pc_valid = 1; pc_addr = 32'h200;
    @(negedge clk);
    chk("t3_acc0", pc_ready, 1);
    tick(1);
    pc_addr = 32'h204;
    @(negedge clk);
    chk("t3_acc1", pc_ready, 1);
    tick(1);
    flush = 1; pc_addr = 32'h300;
    @(negedge clk);
    chk("t3_flush_ready", pc_ready, 0);
    chk("t3_flush_valid", if_valid, 0);
    tick(1);
    flush = 0;
    @(negedge clk);
    chk("t3_drain1", pc_ready, 0);
    tick(1);
    @(negedge clk);
    chk("t3_drain2", pc_ready, 0);
    chk("t3_no_out", pops, 0);
    tick(1);
    @(negedge clk);
    chk("t3_run", pc_ready, 1);
    tick(1);
    pc_valid = 0;
    tick(8);
    chk("t3_pops", pops, 1);
    // 4: flush coinciding with the only response leaves nothing to drain
    lat = 1; pops = 0; pc_valid = 1; pc_addr = 32'h400;
    @(negedge clk);
    chk("t4_acc", pc_ready, 1);
    tick(1);
    pc_valid = 0; flush = 1;
    @(negedge clk);
    chk("t4_flush_valid", if_valid, 0);
    tick(1);
    flush = 0; pc_valid = 1; pc_addr = 32'h500;
    @(negedge clk);
    chk("t4_ready_next", pc_ready, 1);
    chk("t4_dropped", if_valid, 0);
    tick(1);
    pc_valid = 0;
    tick(5);
    chk("t4_pops", pops, 1);
    // 5: misaligned fetch is issued aligned and delivered as a tagged NOP
    pops = 0; pc_valid = 1; pc_addr = 32'h6;
    @(negedge clk);
    chk("t5_mem_req", mem_req, 1);
    chk("t5_mem_addr", mem_addr, 32'h4);
    tick(1);
    pc_valid = 0;
    tick(5);
    chk("t5_pops", pops, 1);
    // 6: reset with three buffered and one in flight
    id_ready = 0; pc_valid = 1; pc_addr = 32'h600;
    for (int i = 0; i < 4; i++) tick(1);
    rst = 1;
    @(negedge clk);
    chk("t6_rst_valid", if_valid, 0);
    chk("t6_rst_ready", pc_ready, 0);
    tick(1);
    rst = 0; acc = 0; pops = 0; pc_addr = 32'h700;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("t6_post_valid", if_valid, 0);
        chk("t6_post_ready", pc_ready, 1);
      end
      took = pc_valid && pc_ready;
      tick(1);
      if (took) pc_addr += 4;
    end
    chk("t6_accepts", acc, 4);
    pc_valid = 0; id_ready = 1;
    tick(8);
    chk("t6_pops", pops, 4);
    chk("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
